// File: rtl/calculator_pkg.sv
// Shared types and constants for the registered 4-bit calculator.
package calculator_pkg;

  localparam int unsigned RESULT_W  = 8;
  localparam int unsigned OPERAND_W = 4;
  localparam logic [RESULT_W-1:0] DIV0_RESULT = 8'hFF;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_MOD = 3'b111
  } opcode_t;

endpackage

// File: rtl/calculator_alu.sv
// Combinational datapath: operands are zero-extended to the result width
// before every operation, so SUB wraps naturally as two's complement.
module calculator_alu
  import calculator_pkg::*;
(
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  input  logic [2:0]           oper,
  output logic [RESULT_W-1:0]  result,
  output logic                 div0
);

  logic [RESULT_W-1:0] ax;
  logic [RESULT_W-1:0] bx;

  assign ax = {{(RESULT_W-OPERAND_W){1'b0}}, a};
  assign bx = {{(RESULT_W-OPERAND_W){1'b0}}, b};

  always_comb begin
    result = '0;
    div0   = 1'b0;
    case (opcode_t'(oper))
      OP_ADD: result = ax + bx;
      OP_SUB: result = ax - bx;
      OP_MUL: result = ax * bx;
      OP_DIV: begin
        if (b == '0) begin
          result = DIV0_RESULT;
          div0   = 1'b1;
        end else begin
          result = ax / bx;
        end
      end
      OP_AND: result = ax & bx;
      OP_OR:  result = ax | bx;
      OP_XOR: result = ax ^ bx;
      OP_MOD: begin
        if (b == '0) begin
          result = DIV0_RESULT;
          div0   = 1'b1;
        end else begin
          result = ax % bx;
        end
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/calculator.sv
// Registered calculator top: one-cycle latency, result and error held
// while idle, synchronous reset takes priority over a pending capture.
module calculator
  import calculator_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  input  logic [2:0]           oper,
  output logic [RESULT_W-1:0]  out,
  output logic                 out_valid,
  output logic                 err
);

  logic [RESULT_W-1:0] result;
  logic                div0;

  calculator_alu u_alu (
    .a      (a),
    .b      (b),
    .oper   (oper),
    .result (result),
    .div0   (div0)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= result;
        err <= div0;
      end
    end
  end

endmodule

// File: tb/tb_calculator.sv
// Directed-vector bench for calculator with a short random tail checked
// against an integer reference model.
module tb_calculator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [2:0] oper = '0;
  logic [7:0] out;
  logic       out_valid;
  logic       err;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  calculator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .oper      (oper),
    .out       (out),
    .out_valid (out_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1ns after the rising edge.
  task automatic step(input logic v, input logic [3:0] va, input logic [3:0] vb,
                      input logic [2:0] vop);
    @(negedge clk);
    in_valid = v;
    a        = va;
    b        = vb;
    oper     = vop;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] eo,
                            input logic ev, input logic ee);
    check({tag, ".out"}, out, eo);
    check({tag, ".valid"}, 8'(out_valid), 8'(ev));
    check({tag, ".err"}, 8'(err), 8'(ee));
  endtask

  function automatic logic [8:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                       input logic [2:0] mop);
    int x;
    int y;
    int r;
    x = int'(ma);
    y = int'(mb);
    r = 0;
    case (mop)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x * y;
      3'd3: if (y == 0) return 9'h1FF; else r = x / y;
      3'd4: r = x & y;
      3'd5: r = x | y;
      3'd6: r = x ^ y;
      default: if (y == 0) return 9'h1FF; else r = x % y;
    endcase
    return {1'b0, 8'(r)};
  endfunction

  logic [7:0] sweep_exp [8];
  logic [7:0] hold_out;
  logic       hold_err;
  logic [8:0] m;
  logic       rv;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [2:0] rop;

  initial begin
    sweep_exp[0] = 8'h0C; sweep_exp[1] = 8'h06; sweep_exp[2] = 8'h1B; sweep_exp[3] = 8'h03;
    sweep_exp[4] = 8'h01; sweep_exp[5] = 8'h0B; sweep_exp[6] = 8'h0A; sweep_exp[7] = 8'h00;

    // Reset state
    rst = 1'b1;
    step(1'b0, 4'd0, 4'd0, 3'd0);
    step(1'b0, 4'd0, 4'd0, 3'd0);
    expect_out("reset", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Opcode sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'd9, 4'd3, 3'(i));
      expect_out($sformatf("sweep%0d", i), sweep_exp[i], 1'b1, 1'b0);
    end

    // Extremes and negative subtract
    step(1'b1, 4'd3, 4'd9, 3'd1);   expect_out("sub3m9", 8'hFA, 1'b1, 1'b0);
    step(1'b1, 4'd15, 4'd15, 3'd2); expect_out("mul15", 8'hE1, 1'b1, 1'b0);
    step(1'b1, 4'd15, 4'd15, 3'd0); expect_out("add15", 8'h1E, 1'b1, 1'b0);
    step(1'b1, 4'd0, 4'd15, 3'd1);  expect_out("sub0m15", 8'hF1, 1'b1, 1'b0);

    // Divide / modulo by zero, then recovery
    step(1'b1, 4'd7, 4'd0, 3'd3);   expect_out("div0", 8'hFF, 1'b1, 1'b1);
    step(1'b1, 4'd7, 4'd0, 3'd7);   expect_out("mod0", 8'hFF, 1'b1, 1'b1);
    step(1'b1, 4'd7, 4'd0, 3'd0);   expect_out("add7p0", 8'h07, 1'b1, 1'b0);

    // Hold while idle, inputs wandering
    step(1'b1, 4'd2, 4'd3, 3'd0);   expect_out("add2p3", 8'h05, 1'b1, 1'b0);
    step(1'b0, 4'd15, 4'd0, 3'd3);  expect_out("hold1", 8'h05, 1'b0, 1'b0);
    step(1'b0, 4'd1, 4'd14, 3'd2);  expect_out("hold2", 8'h05, 1'b0, 1'b0);
    step(1'b0, 4'd8, 4'd8, 3'd6);   expect_out("hold3", 8'h05, 1'b0, 1'b0);

    // err also holds across idle cycles
    step(1'b1, 4'd4, 4'd0, 3'd7);   expect_out("mod0b", 8'hFF, 1'b1, 1'b1);
    step(1'b0, 4'd1, 4'd1, 3'd0);   expect_out("holderr", 8'hFF, 1'b0, 1'b1);

    // Reset beats a simultaneous capture
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 4'd9, 4'd3, 3'd0);   expect_out("rstcap", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 4'd5, 4'd3, 3'd6);   expect_out("xorpost", 8'h06, 1'b1, 1'b0);

    // Random tail with b=0 biased in
    hold_out = 8'h06;
    hold_err = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rv  = 1'($urandom_range(0, 1));
      ra  = 4'($urandom_range(0, 15));
      rb  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      rop = 3'($urandom_range(0, 7));
      step(rv, ra, rb, rop);
      if (rv) begin
        m        = model(ra, rb, rop);
        hold_out = m[7:0];
        hold_err = m[8];
      end
      expect_out($sformatf("rnd%0d", i), hold_out, rv, hold_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
